// File: rtl/mul_52x68_seq.sv
// 52x68-bit product built from four 26x34 partial products issued through one
// external multiplier, with a tag pipe tracking results through its latency.
module mul_52x68_seq #(
    parameter int unsigned MUL_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [51:0]  A,
    input  logic [67:0]  B,
    output logic [25:0]  mul_a,
    output logic [33:0]  mul_b,
    input  logic [59:0]  mul_c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [119:0] C,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state, state_nx;
    logic          live;
    logic          accept;
    logic          issue;
    logic [51:0]   a_q;
    logic [67:0]   b_q;
    logic [1:0]    idx;
    logic [119:0]  acc;
    logic [119:0]  addend;
    logic          tag_ov;
    logic [1:0]    tag_oidx;

    assign issue  = (state == ISSUE);
    assign accept = in_valid && in_ready;

    // Tag pipe mirrors the multiplier depth; with zero depth the issue cycle's own tag is consumed.
    generate
        if (MUL_LAT == 0) begin : g_nopipe
            assign tag_ov   = issue;
            assign tag_oidx = idx;
        end else begin : g_pipe
            logic       tv [MUL_LAT];
            logic [1:0] ti [MUL_LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < MUL_LAT; i++) begin
                        tv[i] <= 1'b0;
                        ti[i] <= '0;
                    end
                end else begin
                    tv[0] <= issue;
                    ti[0] <= idx;
                    for (int unsigned i = 1; i < MUL_LAT; i++) begin
                        tv[i] <= tv[i-1];
                        ti[i] <= ti[i-1];
                    end
                end
            end

            assign tag_ov   = tv[MUL_LAT-1];
            assign tag_oidx = ti[MUL_LAT-1];
        end
    endgenerate

    always_comb begin
        addend = '0;
        case (tag_oidx)
            2'd0: addend = {60'd0, mul_c};
            2'd1: addend = {34'd0, mul_c, 26'd0};
            2'd2: addend = {26'd0, mul_c, 34'd0};
            2'd3: addend = {mul_c, 60'd0};
            default: addend = '0;
        endcase
    end

    // live holds in_ready low until the first edge after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            live  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            idx   <= '0;
            acc   <= '0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (accept) begin
                a_q <= A;
                b_q <= B;
                idx <= '0;
                acc <= '0;
            end else begin
                if (issue)
                    idx <= idx + 2'd1;
                if (tag_ov)
                    acc <= acc + addend;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (accept) state_nx = ISSUE;
            ISSUE: if (idx == 2'd3) state_nx = (MUL_LAT == 0) ? DONE : DRAIN;
            DRAIN: if (tag_ov && tag_oidx == 2'd3) state_nx = DONE;
            DONE:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (issue) begin
            mul_a = idx[0] ? a_q[51:26] : a_q[25:0];
            mul_b = idx[1] ? b_q[67:34] : b_q[33:0];
        end
    end

    assign in_ready  = (state == IDLE) && live;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign C         = acc;

endmodule
